// File: rtl/parking_occupancy_counter.sv
// Parking-lot occupancy counter: synchronizes entry/exit sensors, optionally debounces them
// (define PARKING_SENSOR_DEBOUNCE_EN), and keeps a saturating 0..15 occupancy count.
module parking_occupancy_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter_sensor,
  input  logic       exit_sensor,
  output logic [3:0] fsm_state,
  output logic       full,
  output logic       empty,
  output logic       reject,
  output logic       underflow_err
);

  localparam logic [3:0] CNT_MAX = 4'd15;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end

  // Lane bit 0 is the entry sensor, bit 1 the exit sensor.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt;
  logic [1:0] prev_q;
  logic [1:0] rise;

  logic [3:0] cnt_q, cnt_d;
  logic       reject_q, reject_d;
  logic       underflow_q, underflow_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {exit_sensor, enter_sensor};
      sync2_q <= sync1_q;
    end
  end

`ifdef PARKING_SENSOR_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0][7:0] db_cnt_q, db_cnt_d;
  logic [1:0]      filt_q, filt_d;

  // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
    db_cnt_d = db_cnt_q;
    filt_d   = filt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          filt_d[i]   = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      filt_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  // Clearing prev_q in reset makes a sensor held high through reset count as a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= filt;
  end

  assign rise = filt & ~prev_q;

  always_comb begin
    cnt_d       = cnt_q;
    reject_d    = 1'b0;
    underflow_d = 1'b0;
    case (rise)
      2'b01: begin
        if (cnt_q == CNT_MAX) reject_d = 1'b1;
        else                  cnt_d    = cnt_q + 4'd1;
      end
      2'b10: begin
        if (cnt_q == 4'd0) underflow_d = 1'b1;
        else               cnt_d       = cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  // NOTE: every flop here is a plain register with async reset; there is no memory array to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      reject_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      reject_q    <= reject_d;
      underflow_q <= underflow_d;
    end
  end

  assign fsm_state     = cnt_q;
  assign full          = (cnt_q == CNT_MAX);
  assign empty         = (cnt_q == 4'd0);
  assign reject        = reject_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Self-checking bench for parking_occupancy_counter: directed literal checks plus randomized
// sensor traffic compared every cycle against a behavioural occupancy model.
module tb_parking_occupancy_counter;

`ifdef PARKING_SENSOR_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 3 + DB;
  localparam int HOLD = 2 + DB;
  localparam int GAP  = LAT + DB + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enter_sensor;
  logic       exit_sensor;
  logic [3:0] fsm_state;
  logic       full;
  logic       empty;
  logic       reject;
  logic       underflow_err;

  int n_cmp = 0;
  int n_bad = 0;
  int rej_seen = 0;
  int uf_seen  = 0;

  parking_occupancy_counter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enter_sensor (enter_sensor),
    .exit_sensor  (exit_sensor),
    .fsm_state    (fsm_state),
    .full         (full),
    .empty        (empty),
    .reject       (reject),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Per lane: raw sample history, filtered level history and
  // a run length of samples disagreeing with the filtered level.
  typedef struct {
    bit [1:0] hist;   // hist[0] = sample at previous edge, hist[1] = the one before
    bit       filt;
    int       run;
    bit       f1;     // filtered level after the previous edge
    bit       f2;     // filtered level two edges back
  } lane_t;

  lane_t ln [2];
  int    m_cnt;
  bit    m_rej, m_uf;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ln[i].hist = '0; ln[i].filt = 1'b0; ln[i].run = 0; ln[i].f1 = 1'b0; ln[i].f2 = 1'b0;
    end
    m_cnt = 0; m_rej = 1'b0; m_uf = 1'b0;
  endtask

  task automatic model_edge();
    bit ev [2];
    bit raw [2];
    bit fk;
    raw[0] = enter_sensor;
    raw[1] = exit_sensor;
    for (int i = 0; i < 2; i++) ev[i] = ln[i].f1 && !ln[i].f2;
    m_rej = 1'b0;
    m_uf  = 1'b0;
    if (ev[0] && !ev[1]) begin
      if (m_cnt == 15) m_rej = 1'b1; else m_cnt = m_cnt + 1;
    end else if (ev[1] && !ev[0]) begin
      if (m_cnt == 0) m_uf = 1'b1; else m_cnt = m_cnt - 1;
    end
    for (int i = 0; i < 2; i++) begin
      if (DB == 0) begin
        fk = ln[i].hist[0];
      end else begin
        if (ln[i].hist[1] != ln[i].filt) begin
          ln[i].run = ln[i].run + 1;
          if (ln[i].run == DB) begin
            ln[i].filt = ~ln[i].filt;
            ln[i].run  = 0;
          end
        end else begin
          ln[i].run = 0;
        end
        fk = ln[i].filt;
      end
      ln[i].f2   = ln[i].f1;
      ln[i].f1   = fk;
      ln[i].hist = {ln[i].hist[0], raw[i]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("fsm_state",     8'(fsm_state),     8'(m_cnt));
      check("full",          8'(full),          8'(m_cnt == 15));
      check("empty",         8'(empty),         8'(m_cnt == 0));
      check("reject",        8'(reject),        8'(m_rej));
      check("underflow_err", 8'(underflow_err), 8'(m_uf));
    end
  end

  // Advance n edges; inputs change 2 time units after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      rej_seen += int'(reject);
      uf_seen  += int'(underflow_err);
    end
  endtask

  task automatic pulse(input bit e, input bit x, input int hi);
    enter_sensor = e;
    exit_sensor  = x;
    step(hi);
    enter_sensor = 1'b0;
    exit_sensor  = 1'b0;
    step(GAP);
  endtask

  initial begin
    rst_n = 1'b0;
    enter_sensor = 1'b0;
    exit_sensor  = 1'b0;
    step(3);
    rst_n = 1'b1;
    check("rst_state", 8'(fsm_state), 8'd0);
    check("rst_empty", 8'(empty),     8'd1);
    check("rst_full",  8'(full),      8'd0);
    step(2);

    // First entry: update lands exactly LAT edges after the first high sample.
    enter_sensor = 1'b1;
    step(LAT - 1);
    check("entry_before_lat", 8'(fsm_state), 8'd0);
    enter_sensor = 1'b0;
    step(1);
    check("entry_at_lat",     8'(fsm_state), 8'd1);
    check("entry_empty_drop", 8'(empty),     8'd0);
    step(GAP);
    pulse(1'b1, 1'b0, HOLD);
    pulse(1'b1, 1'b0, HOLD);
    check("three_entries", 8'(fsm_state), 8'd3);

    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, HOLD);
    check("filled",      8'(fsm_state), 8'd15);
    check("filled_full", 8'(full),      8'd1);

    rej_seen = 0;
    pulse(1'b1, 1'b0, HOLD);
    check("reject_hold",  8'(fsm_state), 8'd15);
    check("reject_full",  8'(full),      8'd1);
    check("reject_count", 8'(rej_seen),  8'd1);

    rej_seen = 0;
    uf_seen  = 0;
    pulse(1'b1, 1'b1, HOLD);
    check("simul_at_15",    8'(fsm_state), 8'd15);
    check("simul_no_rej",   8'(rej_seen),  8'd0);

    for (int i = 0; i < 15; i++) pulse(1'b0, 1'b1, HOLD);
    check("drained",       8'(fsm_state), 8'd0);
    check("drained_empty", 8'(empty),     8'd1);

    uf_seen = 0;
    pulse(1'b0, 1'b1, HOLD);
    check("uf_hold",  8'(fsm_state), 8'd0);
    check("uf_count", 8'(uf_seen),   8'd1);

    uf_seen  = 0;
    rej_seen = 0;
    pulse(1'b1, 1'b1, HOLD);
    check("simul_at_0",   8'(fsm_state),           8'd0);
    check("simul_0_flags", 8'(uf_seen + rej_seen), 8'd0);

`ifdef PARKING_SENSOR_DEBOUNCE_EN
    pulse(1'b1, 1'b0, 3);
    check("glitch_ignored", 8'(fsm_state), 8'd0);
`endif

    // Long hold yields a single event.
    enter_sensor = 1'b1;
    step(LAT - 1);
    check("long_before", 8'(fsm_state), 8'd0);
    step(1);
    check("long_at_lat", 8'(fsm_state), 8'd1);
    step(20);
    enter_sensor = 1'b0;
    step(GAP);
    check("long_single", 8'(fsm_state), 8'd1);

    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, HOLD);
    check("at_seven", 8'(fsm_state), 8'd7);

    // Reset mid-flight with the entry sensor still high.
    enter_sensor = 1'b1;
    step(LAT - 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 8'(fsm_state), 8'd0);
    check("async_rst_empty", 8'(empty),     8'd1);
    step(2);
    rst_n = 1'b1;
    step(LAT - 1);
    check("post_rst_before", 8'(fsm_state), 8'd0);
    step(1);
    check("post_rst_event", 8'(fsm_state), 8'd1);
    step(10);
    check("post_rst_single", 8'(fsm_state), 8'd1);
    enter_sensor = 1'b0;
    step(GAP);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int seg = 0; seg < 400; seg++) begin
      int pe;
      pe = ((seg / 50) % 2 == 0) ? 70 : 25;
      enter_sensor = ($urandom_range(99) < pe);
      exit_sensor  = ($urandom_range(99) < (95 - pe));
      step($urandom_range(1, 8 + DB));
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
    end
    enter_sensor = 1'b0;
    exit_sensor  = 1'b0;
    step(GAP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
